// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, memory-op encodings and memory-stage FSM states.
package mem_stage_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 5;
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;
    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
    // The reserved encoding 2'b11 counts as a non-memory op.
    function automatic logic is_mem(input logic [1:0] op);
        return op == MEM_LOAD || op == MEM_STORE;
    endfunction
endpackage

// File: rtl/mem_stage_latch.sv
// mem_stage_latch: EX/MEM pipeline register, loaded on transfer, cleared by reset.
module mem_stage_latch #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mem_op_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic              rd_we_i,
    output logic [1:0]        mem_op_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [RA_W-1:0]   rd_o,
    output logic              rd_we_o
);
    logic [1:0]        mem_op_q, mem_op_d;
    logic [DATA_W-1:0] result_q, result_d, wdata_q, wdata_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic              rd_we_q, rd_we_d;

    always_comb begin
        mem_op_d = en ? mem_op_i : mem_op_q;
        result_d = en ? result_i : result_q;
        wdata_d  = en ? wdata_i  : wdata_q;
        rd_d     = en ? rd_i     : rd_q;
        rd_we_d  = en ? rd_we_i  : rd_we_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_op_q <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            rd_we_q  <= 1'b0;
        end else begin
            mem_op_q <= mem_op_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rd_we_q  <= rd_we_d;
        end
    end

    assign mem_op_o = mem_op_q;
    assign result_o = result_q;
    assign wdata_o  = wdata_q;
    assign rd_o     = rd_q;
    assign rd_we_o  = rd_we_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM latch plus load/store FSM over a req/ack data-memory handshake.
// Retires one instruction per wb_valid pulse; in_ready drops while an access is outstanding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mem_op,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   rd,
    input  logic              rd_we,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RA_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign
);
    state_t            state_q, state_d;
    logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, misalign_q, misalign_d;
    logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [1:0]        op_l;
    logic [DATA_W-1:0] result_l;
    logic [RA_W-1:0]   rd_l;
    logic              rd_we_l, xfer, is_m, go_access, direct, done;

    assign in_ready = state_q != ACCESS;
    assign xfer     = in_valid && in_ready;

    mem_stage_latch #(.DATA_W(DATA_W), .RA_W(RA_W)) u_latch (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (xfer),
        .mem_op_i (mem_op),
        .result_i (result),
        .wdata_i  (wdata),
        .rd_i     (rd),
        .rd_we_i  (rd_we),
        .mem_op_o (op_l),
        .result_o (result_l),
        .wdata_o  (dmem_wdata),
        .rd_o     (rd_l),
        .rd_we_o  (rd_we_l)
    );

    // direct: accepted op retires next cycle without touching memory (none or misaligned).
    always_comb begin
        is_m       = is_mem(mem_op);
        go_access  = xfer && is_m && result[1:0] == 2'b00;
        direct     = xfer && !go_access;
        done       = state_q == ACCESS && dmem_ack;
        state_d    = state_q == ACCESS ? (dmem_ack ? WB : ACCESS)
                   : go_access ? ACCESS : direct ? WB : IDLE;
        dmem_req_d = state_d == ACCESS;
        dmem_we_d  = state_d == ACCESS && (go_access ? mem_op == MEM_STORE : dmem_we_q);
        wb_valid_d = state_d == WB;
        misalign_d = direct && is_m;
        wb_we_d    = done ? op_l == MEM_LOAD && rd_we_l : direct ? rd_we && !is_m : wb_we_q;
        wb_rd_d    = done ? rd_l : direct ? rd : wb_rd_q;
        wb_data_d  = done ? (op_l == MEM_LOAD ? dmem_rdata : result_l) : direct ? result : wb_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign dmem_addr = result_l;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign misalign  = misalign_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage that sits directly downstream of the execute stage.
- Captures the execute outputs (ALU result, store data, jump-free control) into an EX/MEM latch.
- Performs load/store accesses to data memory over a variable-latency req/ack handshake.
- Presents one retired instruction per pulse to writeback, and back-pressures execute via in_ready while an access is outstanding.

Parameters:
- DATA_W, 32, datapath width of result, wdata, dmem bus and wb_data
- RA_W, 5, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  execute has an instruction for this stage
- in_ready  out  1  stage can accept this cycle; transfer = in_valid & in_ready
- mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- result  in  DATA_W  ALU result; load/store address or writeback value
- wdata  in  DATA_W  store data (execute R2 passthrough)
- rd  in  RA_W  destination register
- rd_we  in  1  instruction writes rd
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  word-aligned byte address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  request completes this cycle; rdata valid this cycle for loads
- dmem_rdata  in  DATA_W  load data
- wb_valid  out  1  one-cycle retire pulse to writeback
- wb_we  out  1  register write enable (qualified by wb_valid)
- wb_rd  out  RA_W  destination register
- wb_data  out  DATA_W  load data or ALU result
- misalign  out  1  pulses with wb_valid when a load/store address had addr[1:0] != 0

Behaviour:
- Clock/reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at an edge): state IDLE. All outputs except in_ready are 0, including dmem_*, wb_* and misalign.
- States: IDLE, ACCESS, WB.
- in_ready = 1 in IDLE and WB; 0 in ACCESS.
- Transfer in IDLE or WB:
  - Latch mem_op, result, wdata, rd, rd_we.
  - Non-memory op, or misaligned load/store: next state WB.
  - Aligned load/store: next state ACCESS.
- Misaligned load/store: no dmem_req is issued. In WB, misalign=1 and wb_we=0.
- ACCESS:
  - dmem_req=1; dmem_we=(op==store); dmem_addr=latched result; dmem_wdata=latched wdata. All stable until ack.
  - On dmem_ack: a load captures dmem_rdata into wb_data; next state WB.
- WB, one cycle:
  - wb_valid=1; wb_rd=latched rd.
  - wb_we: latched rd_we for load/none, 0 for store, 0 for misaligned.
  - wb_data: rdata for load, latched result otherwise.
  - No transfer this cycle: next state IDLE.
  - Transfer this cycle: behaves as the IDLE transfer (back-to-back).
- Latency:
  - Non-memory op accepted at edge N: wb_valid in cycle N+1. Throughput is 1 per cycle.
  - Memory op accepted at N: dmem_req from N+1 through ack cycle M inclusive; wb_valid in M+1. Minimum latency is 2 cycles, with ack in the first req cycle.
- dmem_ack while dmem_req=0 is ignored.
- Reset mid-ACCESS: dmem_req drops at the reset edge and the pending instruction is discarded. A late ack after reset is ignored.
- wb_* outputs other than wb_valid hold their last values outside WB; consumers qualify them with wb_valid.
- All outputs registered except in_ready, which is a decode of state.

Decomposition:
- Shared package holds:
  - mem_op encodings: MEM_NONE=2'b00, MEM_LOAD=2'b01, MEM_STORE=2'b10.
  - State enum: IDLE, ACCESS, WB.
  - DATA_W / RA_W defaults, shared with the execute and decode stages.
- One natural sub-module, mem_stage_latch: the EX/MEM pipeline register with load enable = transfer and synchronous clear. The FSM and handshake stay in mem_stage.

Test Plan:
- No memory op: mem_op=00, result=0x0000_002A, rd=5, rd_we=1, accepted at edge 0 -> wb_valid=1 in cycle 1 with wb_data=0x2A, wb_rd=5, wb_we=1; in_ready stays 1.
- Load with 3-cycle wait: mem_op=01, result=0x100; ack in the 3rd req cycle with rdata=0xDEADBEEF -> dmem_req high 3 cycles, addr=0x100, dmem_we=0; in_ready=0 throughout; wb_valid next cycle with wb_data=0xDEADBEEF.
- Store with 0-wait: mem_op=10, result=0x200, wdata=0x1234, ack in the first req cycle -> one-cycle req with dmem_we=1, wdata=0x1234; wb_valid the following cycle with wb_we=0.
- Misaligned access: load with result=0x102 -> no dmem_req; wb_valid next cycle with misalign=1, wb_we=0.
- Back-to-back: three non-memory ops on consecutive cycles, then a load -> wb_valid in 3 consecutive cycles; load req starts the cycle after its transfer, with no bubble at acceptance.
- Reset mid-access: rst_n=0 during req before ack, then ack 0x55 asserted one cycle after release -> dmem_req=0 after the reset edge; wb_valid never asserted; in_ready=1.
